// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner encoding,
// default bus widths and the round-robin pick function.
package mem_arb_pkg;

    typedef logic [31:0] ysyx_23060251_addr_bus;
    typedef logic [31:0] ysyx_23060251_xlen_bus;
    typedef logic [3:0]  ysyx_23060251_mask_bus;

    typedef enum logic [1:0] {
        ysyx_23060251_arb_idle = 2'd0,
        ysyx_23060251_arb_req  = 2'd1,
        ysyx_23060251_arb_wait = 2'd2
    } arb_state_e;

    typedef enum logic {
        ysyx_23060251_arb_if = 1'b0,
        ysyx_23060251_arb_ls = 1'b1
    } arb_owner_e;

    // Under contention the master that did not win last time gets the grant.
    function automatic arb_owner_e arb_pick(input logic if_valid, input logic ls_valid,
                                            input arb_owner_e last);
        if (ls_valid && (!if_valid || last == ysyx_23060251_arb_if)) begin
            return ysyx_23060251_arb_ls;
        end
        return ysyx_23060251_arb_if;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Valid/ready memory request/response bundle, used both between the masters and
// the arbiter and between the arbiter and memory.
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     addr;
    logic                  wen;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_data;
    logic                  resp_err;

    modport master (
        output req_valid, addr, wen, wdata, wmask,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/mem_arb_timeout.sv
// Clearable, enabled, saturating cycle counter; expired_o is high while the
// count sits at TIMEOUT.
module mem_arb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired_o = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_arb.sv
// Two-master (IFU/LSU) arbiter and sequencer onto a single memory port with one
// outstanding transaction, round-robin contention handling and a response timeout.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mem_arb_if.slave  if_bus,
    mem_arb_if.slave  ls_bus,
    mem_arb_if.master mem_bus
);
    localparam int MASK_W = DATA_W / 8;

    arb_state_e          r_state;
    arb_state_e          w_state_next;
    // The owner of the current transaction doubles as the round-robin last_grant.
    arb_owner_e          r_owner;
    arb_owner_e          w_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;

    logic                w_accept;
    logic                w_mem_req_valid;
    logic                w_cnt_clr;
    logic                w_cnt_en;
    logic                w_expired;
    logic                w_resp_fire;
    logic                w_resp_err;
    logic [DATA_W-1:0]   w_resp_data;
    logic [1:0]          w_req_ready;
    logic [1:0]          w_resp_valid_m;
    logic [1:0]          w_resp_err_m;
    logic [DATA_W-1:0]   w_resp_data_m [2];

    assign w_grant  = arb_pick(if_bus.req_valid, ls_bus.req_valid, r_owner);
    assign w_accept = rst_i && (r_state == ysyx_23060251_arb_idle) &&
                      (if_bus.req_valid || ls_bus.req_valid);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ysyx_23060251_arb_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_mem_req_valid = 1'b0;
        w_cnt_clr       = 1'b0;
        w_cnt_en        = 1'b0;
        w_resp_fire     = 1'b0;
        w_resp_err      = 1'b0;
        w_resp_data     = '0;
        case (r_state)
            ysyx_23060251_arb_idle: begin
                if (w_accept) w_state_next = ysyx_23060251_arb_req;
            end
            ysyx_23060251_arb_req: begin
                w_mem_req_valid = 1'b1;
                if (mem_bus.req_ready) begin
                    w_state_next = ysyx_23060251_arb_wait;
                    w_cnt_clr    = 1'b1;
                end
            end
            ysyx_23060251_arb_wait: begin
                w_cnt_en = 1'b1;
                // A real response beats a simultaneous timeout.
                if (mem_bus.resp_valid) begin
                    w_resp_fire  = 1'b1;
                    w_resp_err   = mem_bus.resp_err;
                    w_resp_data  = (r_wen || mem_bus.resp_err) ? '0 : mem_bus.resp_data;
                    w_state_next = ysyx_23060251_arb_idle;
                end else if (w_expired) begin
                    w_resp_fire  = 1'b1;
                    w_resp_err   = 1'b1;
                    w_state_next = ysyx_23060251_arb_idle;
                end
            end
            default: w_state_next = ysyx_23060251_arb_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_owner <= ysyx_23060251_arb_if;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_accept) begin
            r_owner <= w_grant;
            if (w_grant == ysyx_23060251_arb_ls) begin
                r_addr  <= ls_bus.addr;
                r_wen   <= ls_bus.wen;
                r_wdata <= ls_bus.wdata;
                r_wmask <= ls_bus.wmask;
            end else begin
                r_addr  <= if_bus.addr;
                r_wen   <= if_bus.wen;
                r_wdata <= if_bus.wdata;
                r_wmask <= if_bus.wmask;
            end
        end
    end

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_cnt_clr),
        .en_i      (w_cnt_en),
        .expired_o (w_expired)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        localparam arb_owner_e OWN = (gi == 0) ? ysyx_23060251_arb_if : ysyx_23060251_arb_ls;
        assign w_req_ready[gi]    = w_accept && (w_grant == OWN);
        assign w_resp_valid_m[gi] = w_resp_fire && (r_owner == OWN);
        assign w_resp_err_m[gi]   = w_resp_valid_m[gi] && w_resp_err;
        assign w_resp_data_m[gi]  = w_resp_valid_m[gi] ? w_resp_data : '0;
    end

    assign if_bus.req_ready  = w_req_ready[0];
    assign if_bus.resp_valid = w_resp_valid_m[0];
    assign if_bus.resp_err   = w_resp_err_m[0];
    assign if_bus.resp_data  = w_resp_data_m[0];
    assign ls_bus.req_ready  = w_req_ready[1];
    assign ls_bus.resp_valid = w_resp_valid_m[1];
    assign ls_bus.resp_err   = w_resp_err_m[1];
    assign ls_bus.resp_data  = w_resp_data_m[1];

    assign mem_bus.req_valid = w_mem_req_valid;
    assign mem_bus.addr      = r_addr;
    assign mem_bus.wen       = r_wen;
    assign mem_bus.wdata     = r_wdata;
    assign mem_bus.wmask     = r_wmask;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb (TIMEOUT = 4): reset state, single reads/writes,
// round-robin contention, timeout, response/timeout race and mid-request reset.
module tb_mem_arb;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_i;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(32), .DATA_W(32)) if_bus ();
    mem_arb_if #(.ADDR_W(32), .DATA_W(32)) ls_bus ();
    mem_arb_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_arb #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .if_bus  (if_bus),
        .ls_bus  (ls_bus),
        .mem_bus (mem_bus)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet_inputs();
        if_bus.req_valid   = 1'b0; if_bus.addr = '0; if_bus.wen = 1'b0;
        if_bus.wdata       = '0;   if_bus.wmask = '0;
        ls_bus.req_valid   = 1'b0; ls_bus.addr = '0; ls_bus.wen = 1'b0;
        ls_bus.wdata       = '0;   ls_bus.wmask = '0;
        mem_bus.req_ready  = 1'b0;
        mem_bus.resp_valid = 1'b0;
        mem_bus.resp_data  = '0;
        mem_bus.resp_err   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int   n_grant;
    int   n_resp;
    logic exp_ls;
    logic owner_ls;

    initial begin
        // ---------------- reset state (requests pending during reset)
        rst_i = 1'b0;
        quiet_inputs();
        if_bus.req_valid = 1'b1;
        ls_bus.req_valid = 1'b1;
        cyc(); cyc();
        #1;
        chk("rst_ready", {ls_bus.req_ready, if_bus.req_ready}, 0);
        chk("rst_if_resp", {if_bus.resp_valid, if_bus.resp_err, if_bus.resp_data}, 0);
        chk("rst_ls_resp", {ls_bus.resp_valid, ls_bus.resp_err, ls_bus.resp_data}, 0);
        chk("rst_mem", {mem_bus.req_valid, mem_bus.addr, mem_bus.wen, mem_bus.wdata, mem_bus.wmask}, 0);
        quiet_inputs();
        rst_i = 1'b1;

        // ---------------- IFU read, minimum latency
        cyc();
        if_bus.req_valid = 1'b1; if_bus.addr = 32'h8000_0000; if_bus.wen = 1'b0;
        #1;
        chk("t1_accept", {ls_bus.req_ready, if_bus.req_ready}, 2'b01);
        chk("t1_mem_idle", mem_bus.req_valid, 1'b0);
        cyc();
        if_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
        #1;
        chk("t1_req", {mem_bus.req_valid, mem_bus.addr, mem_bus.wen}, {1'b1, 32'h8000_0000, 1'b0});
        cyc();
        mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b1;
        mem_bus.resp_data = 32'hDEAD_BEEF; mem_bus.resp_err = 1'b0;
        #1;
        chk("t1_if_resp", {if_bus.resp_valid, if_bus.resp_err, if_bus.resp_data}, {1'b1, 1'b0, 32'hDEAD_BEEF});
        chk("t1_ls_quiet", {ls_bus.resp_valid, ls_bus.resp_err, ls_bus.resp_data, ls_bus.req_ready}, 0);
        $display("txn IF read  addr=0x80000000 data=0x%08h err=%0b", if_bus.resp_data, if_bus.resp_err);
        cyc();
        mem_bus.resp_valid = 1'b0;
        #1;
        chk("t1_done", {if_bus.resp_valid, mem_bus.req_valid}, 0);

        // ---------------- contention from reset: LS, IF, LS, IF ...
        cyc();
        rst_i = 1'b0;
        if_bus.req_valid = 1'b1; if_bus.addr = 32'h0000_1000;
        ls_bus.req_valid = 1'b1; ls_bus.addr = 32'h0000_2000;
        mem_bus.req_ready = 1'b1; mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'h11;
        cyc();
        rst_i = 1'b1;
        exp_ls = 1'b1; owner_ls = 1'b0; n_grant = 0; n_resp = 0;
        for (int c = 0; c < 40 && n_resp < 8; c++) begin
            #1;
            if (if_bus.req_ready || ls_bus.req_ready) begin
                chk($sformatf("rr_grant%0d", n_grant), {ls_bus.req_ready, if_bus.req_ready},
                    exp_ls ? 2'b10 : 2'b01);
                owner_ls = exp_ls;
                exp_ls   = !exp_ls;
                n_grant++;
            end
            if (if_bus.resp_valid || ls_bus.resp_valid) begin
                chk($sformatf("rr_resp%0d", n_resp), {ls_bus.resp_valid, if_bus.resp_valid},
                    owner_ls ? 2'b10 : 2'b01);
                $display("txn %s read  (contention #%0d)", owner_ls ? "LS" : "IF", n_resp);
                n_resp++;
                if (n_resp == 8) begin
                    if_bus.req_valid = 1'b0;
                    ls_bus.req_valid = 1'b0;
                end
            end
            cyc();
        end
        chk("rr_count", n_resp, 8);
        quiet_inputs();

        // ---------------- LSU write with memory back-pressure
        cyc();
        ls_bus.req_valid = 1'b1; ls_bus.addr = 32'h8000_0010; ls_bus.wen = 1'b1;
        ls_bus.wdata = 32'h1234_5678; ls_bus.wmask = 4'b0011;
        #1;
        chk("t3_accept", {ls_bus.req_ready, if_bus.req_ready}, 2'b10);
        cyc();
        ls_bus.req_valid = 1'b0; ls_bus.addr = 32'hFFFF_FFFC; ls_bus.wdata = 32'h0; ls_bus.wmask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t3_hold%0d", i),
                {mem_bus.req_valid, mem_bus.addr, mem_bus.wen, mem_bus.wdata, mem_bus.wmask},
                {1'b1, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'b0011});
            cyc();
        end
        mem_bus.req_ready = 1'b1;
        #1;
        chk("t3_req_last", mem_bus.req_valid, 1'b1);
        cyc();
        mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'hFFFF_FFFF;
        #1;
        chk("t3_ls_resp", {ls_bus.resp_valid, ls_bus.resp_err, ls_bus.resp_data}, {1'b1, 1'b0, 32'h0});
        chk("t3_if_quiet", if_bus.resp_valid, 1'b0);
        $display("txn LS write addr=0x80000010 data=0x%08h err=%0b", ls_bus.resp_data, ls_bus.resp_err);
        cyc();
        quiet_inputs();

        // ---------------- timeout with no response, then a late response
        if_bus.req_valid = 1'b1; if_bus.addr = 32'h8000_0020;
        #1;
        chk("t4_accept", if_bus.req_ready, 1'b1);
        cyc();
        if_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
        #1;
        chk("t4_req", mem_bus.req_valid, 1'b1);
        cyc();
        mem_bus.req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t4_wait%0d", i), if_bus.resp_valid, 1'b0);
            cyc();
        end
        #1;
        chk("t4_timeout", {if_bus.resp_valid, if_bus.resp_err, if_bus.resp_data}, {1'b1, 1'b1, 32'h0});
        $display("txn IF read  addr=0x80000020 data=0x%08h err=%0b (timeout)", if_bus.resp_data, if_bus.resp_err);
        cyc();
        mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'h99;
        #1;
        chk("t4_late_ignored", {ls_bus.resp_valid, if_bus.resp_valid}, 2'b00);
        cyc();
        quiet_inputs();

        // ---------------- response and timeout in the same cycle
        ls_bus.req_valid = 1'b1; ls_bus.addr = 32'h8000_0030;
        #1;
        chk("t5_accept", ls_bus.req_ready, 1'b1);
        cyc();
        ls_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
        cyc();
        mem_bus.req_ready = 1'b0;
        repeat (4) cyc();
        mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'h55; mem_bus.resp_err = 1'b0;
        #1;
        chk("t5_race", {ls_bus.resp_valid, ls_bus.resp_err, ls_bus.resp_data}, {1'b1, 1'b0, 32'h55});
        $display("txn LS read  addr=0x80000030 data=0x%08h err=%0b (race)", ls_bus.resp_data, ls_bus.resp_err);
        cyc();
        quiet_inputs();

        // ---------------- reset during REQ
        if_bus.req_valid = 1'b1; if_bus.addr = 32'h8000_0040;
        cyc();
        if_bus.req_valid = 1'b0;
        #1;
        chk("t6_in_req", mem_bus.req_valid, 1'b1);
        rst_i = 1'b0;
        #1;
        chk("t6_drop", mem_bus.req_valid, 1'b0);
        cyc();
        rst_i = 1'b1;
        mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'h77;
        #1;
        chk("t6_no_resp", {if_bus.resp_valid, ls_bus.resp_valid, mem_bus.req_valid}, 0);
        cyc();
        mem_bus.resp_valid = 1'b0;
        if_bus.req_valid = 1'b1; if_bus.addr = 32'h8000_0044;
        #1;
        chk("t6_accept", {ls_bus.req_ready, if_bus.req_ready}, 2'b01);
        cyc();
        if_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
        #1;
        chk("t6_req", {mem_bus.req_valid, mem_bus.addr}, {1'b1, 32'h8000_0044});
        cyc();
        mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 32'hCAFE_F00D;
        #1;
        chk("t6_resp", {if_bus.resp_valid, if_bus.resp_err, if_bus.resp_data}, {1'b1, 1'b0, 32'hCAFE_F00D});
        $display("txn IF read  addr=0x80000044 data=0x%08h err=%0b", if_bus.resp_data, if_bus.resp_err);
        cyc();
        quiet_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
